seq1001_tx: RTL

//  Serial stimulus transmitter for the 1001 non-overlapping Mealy detector path.

---
 rtl/seq1001_pkg.sv | 45 ++++
 rtl/seq1001_ref_fsm.sv | 35 +++
 rtl/seq1001_tx.sv | 111 +++++++++++
 3 files changed

// File: rtl/seq1001_pkg.sv
// ---------------------------------------------------------------------------
// seq1001_pkg
//   Shared definitions for the 1001 serial stimulus transmitter and its
//   non-overlapping Mealy reference model.
//
//   Contents:
//     tx_state_e   transmitter FSM states (TX_IDLE, TX_SHIFT)
//     det_state_e  reference detector states (DET_S0, DET_S1, DET_S10,
//                  DET_S100), 2-bit encoding
//     PATTERN      the detected sequence, 4'b1001, first bit in [3]
//     det_next()   next-state function of the reference detector
// ---------------------------------------------------------------------------
package seq1001_pkg;

    typedef enum logic [0:0] {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_e;

    typedef enum logic [1:0] {
        DET_S0   = 2'd0,
        DET_S1   = 2'd1,
        DET_S10  = 2'd2,
        DET_S100 = 2'd3
    } det_state_e;

    localparam logic [3:0] PATTERN = 4'b1001;

    // Each state names the prefix of PATTERN already matched. A bit that
    // breaks the match falls back to S1 when it is a 1 (a fresh leading 1),
    // otherwise to S0. Completing the pattern from S100 returns to S0 so
    // that matches never share bits.
    function automatic det_state_e det_next(input det_state_e cur, input logic bitIn);
        det_state_e nxt;
        case (cur)
            DET_S0:   nxt = (bitIn == PATTERN[3]) ? DET_S1   : DET_S0;
            DET_S1:   nxt = (bitIn == PATTERN[2]) ? DET_S10  : DET_S1;
            DET_S10:  nxt = (bitIn == PATTERN[1]) ? DET_S100 : DET_S1;
            DET_S100: nxt = DET_S0;
            default:  nxt = DET_S0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/seq1001_ref_fsm.sv
// ---------------------------------------------------------------------------
// seq1001_ref_fsm
//   Golden non-overlapping 1001 Mealy detector. Clocked on the serial line
//   every cycle (idle bits included) and reports where a compliant detector
//   must fire. Usable on its own as the reference in detector benches.
//
//   Ports:
//     clk_i      rising-edge clock
//     rst_ni     asynchronous reset, active-low (state returns to DET_S0)
//     signal_i   serial bit observed this cycle
//     exp_out_o  1 in the same cycle as the final bit of a 1001 match
// ---------------------------------------------------------------------------
module seq1001_ref_fsm
    import seq1001_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic signal_i,
    output logic exp_out_o
);

    det_state_e state_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= DET_S0;
        end else begin
            state_q <= det_next(state_q, signal_i);
        end
    end

    // Mealy output: fires combinationally with the fourth pattern bit.
    assign exp_out_o = (state_q == DET_S100) & (signal_i == PATTERN[0]);

endmodule

// File: rtl/seq1001_tx.sv
// ---------------------------------------------------------------------------
// seq1001_tx
//   Serial stimulus transmitter for the 1001 detector path. Parallel words
//   arrive over a load/ready handshake and are shifted out MSB-first on a
//   registered 1-bit line, one bit per clock, with no gap between words
//   when load is held across the final bit.
//
//   Parameters:
//     WIDTH       bits per word, legal 2..32 (default 8)
//     IDLE_LEVEL  level driven on signal_o when no word is in flight
//
//   Ports:
//     clk_i      rising-edge clock
//     rst_ni     asynchronous reset, active-low; aborts any word in flight
//     load_i     word valid; accepted when load_i && ready_o at a rising edge
//     data_in_i  word to serialise, MSB first
//     ready_o    a word can be accepted this cycle
//     signal_o   registered serial output
//     busy_o     a word bit is on signal_o this cycle
//     last_o     the LSB of the word is on signal_o this cycle
//     exp_out_o  expected detector output (only with SEQ1001_TX_EXPECT_EN)
//
//   Build option:
//     SEQ1001_TX_EXPECT_EN  adds exp_out_o driven by an internal
//                           seq1001_ref_fsm watching signal_o.
// ---------------------------------------------------------------------------
module seq1001_tx
    import seq1001_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_in_i,
    output logic             ready_o,
    output logic             signal_o,
    output logic             busy_o,
    output logic             last_o
`ifdef SEQ1001_TX_EXPECT_EN
    ,
    output logic             exp_out_o
`endif
);

    localparam int CW = $clog2(WIDTH);

    tx_state_e        state_q;
    logic [WIDTH-1:0] shift_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             signal_q;
    logic             busy_q;
    logic             last_q;
    logic             accept;

    // Ready depends only on registered state so the sender may derive load
    // from it without creating a combinational loop.
    assign ready_o = (state_q == TX_IDLE) | last_q;
    assign accept  = load_i & ready_o;
    assign cnt_d   = cnt_q - CW'(1);

    // The MSB goes straight to the output register on the accepting edge;
    // shift_q keeps the remaining bits left-aligned so its top bit is always
    // the next one to send. The counter tracks bits still to come after the
    // one on the line and is only reloaded on accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= TX_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            signal_q <= IDLE_LEVEL;
            busy_q   <= 1'b0;
            last_q   <= 1'b0;
        end else if (accept) begin
            state_q  <= TX_SHIFT;
            shift_q  <= {data_in_i[WIDTH-2:0], 1'b0};
            cnt_q    <= CW'(WIDTH - 1);
            signal_q <= data_in_i[WIDTH-1];
            busy_q   <= 1'b1;
            last_q   <= 1'b0;
        end else if (state_q == TX_SHIFT) begin
            if (last_q) begin
                state_q  <= TX_IDLE;
                signal_q <= IDLE_LEVEL;
                busy_q   <= 1'b0;
                last_q   <= 1'b0;
            end else begin
                shift_q  <= {shift_q[WIDTH-2:0], 1'b0};
                cnt_q    <= cnt_d;
                signal_q <= shift_q[WIDTH-1];
                last_q   <= (cnt_d == '0);
            end
        end
    end

    assign signal_o = signal_q;
    assign busy_o   = busy_q;
    assign last_o   = last_q;

`ifdef SEQ1001_TX_EXPECT_EN
    seq1001_ref_fsm u_ref_fsm (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .signal_i  (signal_q),
        .exp_out_o (exp_out_o)
    );
`endif

endmodule
